// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator pair comparator: FSM state
// encoding, default widths and a small elaboration-time helper.
package puf_pkg;

    // Default widths of the challenge index and of each edge counter.
    localparam int SEL_W_DEF = 4;
    localparam int CNT_W_DEF = 16;

    // Comparison sequence: settle/count on oscillator A, then on B, then report.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE_A = 3'd1,
        ST_COUNT_A  = 3'd2,
        ST_SETTLE_B = 3'd3,
        ST_COUNT_B  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Larger of two integers; used to size the shared phase timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a
// rising-edge detector working on the synchronized signal.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Synchronizer chain plus one extra stage holding the previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    // One-cycle pulse on every low-to-high transition of the synchronized input.
    assign rise = sync_reg & ~prev_reg;

endmodule

// File: rtl/ro_pair_compare.sv
// Ring-oscillator PUF cell: selects two oscillators in turn through an
// external mux, counts the rising edges of each over a fixed window and
// reports which one is faster.
module ro_pair_compare
    import puf_pkg::*;
#(
    parameter int SEL_W  = SEL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WINDOW = 64,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] chal_a,
    input  logic [SEL_W-1:0] chal_b,
    output logic [SEL_W-1:0] sel,
    input  logic             ro_in,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    // One down-counter times every settle and count phase, so it must hold
    // the larger of the two phase lengths.
    localparam int TMR_MAX = max_int(SETTLE, WINDOW);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [SEL_W-1:0] chal_a_reg;
    logic [SEL_W-1:0] chal_b_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [CNT_W-1:0] cnt_a_reg;
    logic [CNT_W-1:0] cnt_b_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             resp_reg;
    logic             ro_rise;
    logic             timer_zero;

    // ro_in is asynchronous to clk; only synchronized rising edges are counted.
    edge_sync u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (ro_in),
        .rise (ro_rise)
    );

    assign timer_zero = (timer_reg == '0);

    // Sequencer, shared phase timer, saturating edge counters and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            timer_reg  <= '0;
            chal_a_reg <= '0;
            chal_b_reg <= '0;
            sel_reg    <= '0;
            cnt_a_reg  <= '0;
            cnt_b_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            resp_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // sel keeps its last value while idle.
                    if (start) begin
                        chal_a_reg <= chal_a;
                        chal_b_reg <= chal_b;
                        sel_reg    <= chal_a;
                        cnt_a_reg  <= '0;
                        cnt_b_reg  <= '0;
                        timer_reg  <= SETTLE_LOAD;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_SETTLE_A;
                    end
                end

                ST_SETTLE_A: begin
                    // Mux output and synchronizer settle; edges are discarded.
                    sel_reg <= chal_a_reg;
                    if (timer_zero) begin
                        timer_reg <= WINDOW_LOAD;
                        state_reg <= ST_COUNT_A;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                ST_COUNT_A: begin
                    sel_reg <= chal_a_reg;
                    if (ro_rise && (cnt_a_reg != CNT_MAX)) begin
                        cnt_a_reg <= cnt_a_reg + 1'b1;
                    end
                    if (timer_zero) begin
                        sel_reg   <= chal_b_reg;
                        timer_reg <= SETTLE_LOAD;
                        state_reg <= ST_SETTLE_B;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                ST_SETTLE_B: begin
                    sel_reg <= chal_b_reg;
                    if (timer_zero) begin
                        timer_reg <= WINDOW_LOAD;
                        state_reg <= ST_COUNT_B;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                ST_COUNT_B: begin
                    sel_reg <= chal_b_reg;
                    if (ro_rise && (cnt_b_reg != CNT_MAX)) begin
                        cnt_b_reg <= cnt_b_reg + 1'b1;
                    end
                    if (timer_zero) begin
                        state_reg <= ST_DONE;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                ST_DONE: begin
                    // Both counts are final here; a tie reports 0.
                    sel_reg   <= chal_b_reg;
                    resp_reg  <= (cnt_a_reg > cnt_b_reg);
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel   = sel_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign resp  = resp_reg;
    assign cnt_a = cnt_a_reg;
    assign cnt_b = cnt_b_reg;

endmodule

// File: tb/tb_ro_pair_compare.sv
// Bench for ro_pair_compare: a 16-oscillator array behind a 16:1 mux, with
// directed and randomized comparisons checked against an arithmetic model.
module tb_ro_pair_compare;

    localparam int WINDOW = 64;
    localparam int SETTLE = 4;
    localparam int LAT    = 1 + 2 * (SETTLE + WINDOW);

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main instance (default widths).
    logic        start = 1'b0;
    logic [3:0]  chal_a = '0;
    logic [3:0]  chal_b = '0;
    logic [3:0]  sel;
    logic        ro_in;
    logic        busy, done, resp;
    logic [15:0] cnt_a, cnt_b;

    // Narrow-counter instance for saturation.
    logic        start_s = 1'b0;
    logic [3:0]  chal_a_s = '0;
    logic [3:0]  chal_b_s = '0;
    logic [3:0]  sel_s;
    logic        ro_in_s;
    logic        busy_s, done_s, resp_s;
    logic [3:0]  cnt_a_s, cnt_b_s;

    // Oscillator i toggles every per[i] clk cycles.
    int per [16] = '{1, 32, 16, 2, 8, 4, 1, 16, 32, 4, 2, 8, 1, 16, 4, 2};
    int cyc = 0;
    logic [15:0] osc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        osc = '0;
        for (int i = 0; i < 16; i++) osc[i] = (((cyc / per[i]) % 2) == 1);
    end

    function automatic logic mux_16to1(input logic [15:0] v, input logic [3:0] s);
        return v[s];
    endfunction

    assign ro_in   = mux_16to1(osc, sel);
    assign ro_in_s = mux_16to1(osc, sel_s);

    ro_pair_compare #(.SEL_W(4), .CNT_W(16), .WINDOW(WINDOW), .SETTLE(SETTLE)) u_dut (
        .clk(clk), .rst(rst), .start(start), .chal_a(chal_a), .chal_b(chal_b),
        .sel(sel), .ro_in(ro_in), .busy(busy), .done(done), .resp(resp),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    ro_pair_compare #(.SEL_W(4), .CNT_W(4), .WINDOW(WINDOW), .SETTLE(SETTLE)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .chal_a(chal_a_s), .chal_b(chal_b_s),
        .sel(sel_s), .ro_in(ro_in_s), .busy(busy_s), .done(done_s), .resp(resp_s),
        .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
    );

    // Reference: a square wave of half-period p has WINDOW/(2p) rising edges in
    // any WINDOW consecutive cycles (all periods here divide WINDOW), clipped at
    // the counter maximum.
    function automatic int model_cnt(input int idx, input int cmax);
        int n;
        n = WINDOW / (2 * per[idx]);
        return (n > cmax) ? cmax : n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one comparison on the main instance and wait for done.
    task automatic run_main(input logic [3:0] a, input logic [3:0] b, input bit hold,
                            output int lat, output int sel_first, output int sel_mid);
        chal_a = a;
        chal_b = b;
        start  = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        sel_first = int'(sel);
        sel_mid   = -1;
        lat       = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (!hold) begin
                chal_a = 4'($urandom_range(15));
                chal_b = 4'($urandom_range(15));
            end
            if (n == 100) sel_mid = int'(sel);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_run(input string tag, input int a, input int b,
                             input int lat, input int sel_first, input int sel_mid);
        int ea, eb;
        ea = model_cnt(a, 65535);
        eb = model_cnt(b, 65535);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_sel_a"}, sel_first, a);
        check({tag, "_sel_b"}, sel_mid, b);
        check({tag, "_cnt_a"}, int'(cnt_a), ea);
        check({tag, "_cnt_b"}, int'(cnt_b), eb);
        check({tag, "_resp"}, int'(resp), (ea > eb) ? 1 : 0);
        check({tag, "_busy_low"}, int'(busy), 0);
        $display("run %s: chal_a=%0d chal_b=%0d cnt_a=%0d cnt_b=%0d resp=%0d lat=%0d",
                 tag, a, b, cnt_a, cnt_b, resp, lat);
    endtask

    initial begin
        int lat, s1, s2, nd, ra, rb;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_cnt_b", int'(cnt_b), 0);
        check("rst_resp", int'(resp), 0);
        repeat (2) @(posedge clk);
        #1;

        // Faster oscillator first.
        run_main(4'd3, 4'd9, 1'b0, lat, s1, s2);
        check_run("a3_b9", 3, 9, lat, s1, s2);
        check("a3_b9_exp16", int'(cnt_a), 16);
        check("a3_b9_exp8", int'(cnt_b), 8);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
        check("cnt_held", int'(cnt_a), 16);

        // Swapped order.
        run_main(4'd9, 4'd3, 1'b0, lat, s1, s2);
        check_run("a9_b3", 9, 3, lat, s1, s2);

        // Same oscillator twice: tie gives 0.
        run_main(4'd5, 4'd5, 1'b0, lat, s1, s2);
        check_run("a5_b5", 5, 5, lat, s1, s2);
        check("tie_equal", int'(cnt_a == cnt_b), 1);

        // Randomized challenge pairs.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom_range(15);
            rb = $urandom_range(15);
            run_main(4'(ra), 4'(rb), 1'b0, lat, s1, s2);
            check_run("rand", ra, rb, lat, s1, s2);
        end

        // Back-to-back: start held high through done begins the next run at once.
        run_main(4'd3, 4'd9, 1'b1, lat, s1, s2);
        check_run("b2b_1", 3, 9, lat, s1, s2);
        run_main(4'd12, 4'd1, 1'b0, lat, s1, s2);
        check_run("b2b_2", 12, 1, lat, s1, s2);

        // Reset in the middle of COUNT_A.
        chal_a = 4'd3;
        chal_b = 4'd9;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (SETTLE + 20) @(posedge clk);
        #1;
        check("midrst_partial", int'(cnt_a != 0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_cnt_a", int'(cnt_a), 0);
        check("midrst_sel", int'(sel), 0);
        nd = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("midrst_no_done", nd, 0);
        $display("run midrst: dones_after_reset=%0d", nd);

        // Saturation with a 4-bit counter, plus extra start pulses while busy.
        chal_a_s = 4'd0;
        chal_b_s = 4'd1;
        start_s  = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        nd = 0;
        ra = -1;
        rb = -1;
        s1 = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            start_s = (n == 10 || n == 50 || n == 100);
            if (done_s) begin
                nd++;
                ra = int'(cnt_a_s);
                rb = int'(cnt_b_s);
                s1 = int'(resp_s);
            end
        end
        check("sat_done_count", nd, 1);
        check("sat_cnt_a", ra, model_cnt(0, 15));
        check("sat_cnt_b", rb, model_cnt(1, 15));
        check("sat_resp", s1, 1);
        $display("run sat: dones=%0d cnt_a=%0d cnt_b=%0d resp=%0d", nd, ra, rb, s1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ro_pair_compare.md
RO_PAIR_COMPARE -- requirements
Module: ro_pair_compare

Interface
REQ-001 SHALL have parameter SEL_W, default 4, meaning the width of the mux select and challenge index.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the edge-counter width.
REQ-003 SHALL have parameter WINDOW, default 64, meaning the number of clk cycles in each count window (at least 1).
REQ-004 SHALL have parameter SETTLE, default 4, meaning the cycles waited after each sel change before counting (at least 3).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: request one comparison; sampled only in IDLE.
REQ-008 SHALL have port chal_a, input, SEL_W bits: first oscillator index.
REQ-009 SHALL have port chal_b, input, SEL_W bits: second oscillator index.
REQ-010 SHALL have port sel, output, SEL_W bits: drives the select input of the 16:1 oscillator mux.
REQ-011 SHALL have port ro_in, input, 1 bit: the mux output; asynchronous to clk.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-014 SHALL have port resp, output, 1 bit: the PUF response bit.
REQ-015 SHALL have ports cnt_a and cnt_b, output, CNT_W bits each: raw edge counts, held until the next start.

Function
REQ-016 SHALL sequence the FSM IDLE -> SETTLE_A -> COUNT_A -> SETTLE_B -> COUNT_B -> DONE -> IDLE.
REQ-017 SHALL latch chal_a and chal_b in the cycle start is accepted in IDLE; input changes while busy SHALL have no effect.
REQ-018 SHALL drive sel from the latched chal_a during SETTLE_A and COUNT_A, from the latched chal_b during SETTLE_B, COUNT_B and DONE, and hold sel at its last value in IDLE.
REQ-019 SHALL remain in each SETTLE state exactly SETTLE cycles and in each COUNT state exactly WINDOW cycles, using one shared down-counter.
REQ-020 SHALL pass ro_in through a 2-flop synchronizer followed by a rising-edge detector.
REQ-021 SHALL increment the active counter by 1 only in COUNT cycles where the edge detector fires; edges in SETTLE or IDLE are discarded.
REQ-022 SHALL saturate each counter at 2^CNT_W-1 rather than wrapping.
REQ-023 SHALL clear both counters on start acceptance.
REQ-024 SHALL set resp = 1 when cnt_a > cnt_b, else 0; a tie gives 0, including chal_a == chal_b.
REQ-025 SHALL update resp, assert done for exactly one cycle, and deassert busy the following cycle, all in DONE.
REQ-026 Latency: SHALL assert done in cycle k+1+2*(SETTLE+WINDOW) when start is sampled at edge k.
REQ-027 SHALL ignore start while busy; start high in the same cycle as DONE is also ignored and is accepted only from IDLE.
REQ-028 SHALL accept back-to-back comparisons: start held high SHALL begin a new run in the first IDLE cycle.

Reset
REQ-029 On rst high at a clk edge, SHALL force state IDLE; sel, cnt_a, cnt_b, resp, done, busy, the synchronizer flops and the latched challenges SHALL all go to 0.
REQ-030 Reset SHALL take priority over start and over any state, including mid-COUNT; a partial count SHALL be discarded and no done SHALL be produced.

Structure
REQ-031 SHALL define the FSM state encoding and the default SEL_W/CNT_W values as constants in the shared package puf_pkg.
REQ-032 SHALL implement the synchronizer and edge detector as sub-module edge_sync (ports clk, rst, d, rise), instantiated once.
REQ-033 SHALL keep the implementation within 120-400 RTL lines.

Verification
REQ-034 Bench models a 16-oscillator array behind mux_16to1; oscillator i toggles every P[i] clk cycles. Use WINDOW=64, SETTLE=4.
REQ-035 Scenario: P[3]=2 (period 4), P[9]=4 (period 8), chal_a=3, chal_b=9, start pulse at k -> cnt_a=16, cnt_b=8, resp=1, done at k+137, sel=3 then 9.
REQ-036 Scenario: same oscillators with chal_a=9, chal_b=3 -> cnt_a=8, cnt_b=16, resp=0.
REQ-037 Scenario: chal_a=chal_b=5 -> cnt_a == cnt_b, resp=0.
REQ-038 Scenario: rst pulsed 20 cycles into COUNT_A -> next cycle busy=0, cnt_a=0, sel=0, and no done within 200 cycles.
REQ-039 Scenario: CNT_W=4, oscillator period 2 -> cnt_a=15 (saturated) with no wrap; start pulses while busy -> exactly one done per accepted start.
